// File: rtl/parser_ingress_arbiter.sv
// Frame-granular round-robin arbiter that shares one header parser between
// NUM_PORTS AXI-Stream ingress ports and tags each frame with its source port.
module parser_ingress_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 64,
    parameter int TAG_DEPTH = 4,
    localparam int ID_W     = $clog2(NUM_PORTS)
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [NUM_PORTS*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]        s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]        s_axis_tlast,
    output logic [NUM_PORTS-1:0]        s_axis_tready,
    output logic [DATA_W-1:0]           m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    input  logic                        m_axis_tready,
    output logic [ID_W-1:0]             m_axis_tid,
    input  logic                        header_done,
    output logic [ID_W-1:0]             hdr_src_id,
    output logic                        hdr_src_valid,
    output logic                        tag_full,
    output logic                        tag_err,
    output logic                        busy
);

    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = PW + 1;
    localparam int unsigned NP_U = NUM_PORTS;

    typedef enum logic {IDLE, XFER} state_t;

    state_t          state;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] cand;
    logic            pick_valid;
    logic            push;
    logic            pop;
    logic            beat_last;

    logic [ID_W-1:0] tag_mem [TAG_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    // First requester searching upward from the port after the last winner.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int unsigned off = 1; off <= NP_U; off++) begin
            cand = ID_W'((32'(last_grant) + off) % NP_U);
            if (!pick_valid && s_axis_tvalid[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
    end

    assign push      = (state == IDLE) && pick_valid && !tag_full;
    assign beat_last = (state == XFER) && m_axis_tvalid && m_axis_tready && m_axis_tlast;
    assign pop       = header_done && (count != '0);

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        if (state == XFER) begin
            m_axis_tdata         = s_axis_tdata[32'(grant)*DATA_W +: DATA_W];
            m_axis_tvalid        = s_axis_tvalid[grant];
            m_axis_tlast         = s_axis_tlast[grant];
            s_axis_tready[grant] = m_axis_tready;
        end
    end

    assign m_axis_tid = grant;
    assign busy       = (state == XFER);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= ID_W'(NUM_PORTS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (push) begin
                        grant <= pick;
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (beat_last) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            tag_mem[wr_ptr] <= pick;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            tag_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (header_done && (count == '0)) begin
                tag_err <= 1'b1;
            end
        end
    end

    assign hdr_src_id    = tag_mem[rd_ptr];
    assign hdr_src_valid = (count != '0);
    assign tag_full      = (count == CW'(TAG_DEPTH));

endmodule

// File: tb/tb_parser_ingress_arbiter.sv
// Randomised and directed bench for parser_ingress_arbiter, checked against
// a frame-level model (owner/last winner/tag queue) and a per-port scoreboard.
module tb_parser_ingress_arbiter;

    localparam int NP = 4;
    localparam int DW = 64;
    localparam int TD = 4;
    localparam int IW = 2;

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic [NP*DW-1:0]  s_axis_tdata = '0;
    logic [NP-1:0]     s_axis_tvalid = '0;
    logic [NP-1:0]     s_axis_tlast = '0;
    logic [NP-1:0]     s_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready = 1'b1;
    logic [IW-1:0]     m_axis_tid;
    logic              header_done = 1'b0;
    logic [IW-1:0]     hdr_src_id;
    logic              hdr_src_valid;
    logic              tag_full;
    logic              tag_err;
    logic              busy;

    parser_ingress_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .TAG_DEPTH(TD)) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .m_axis_tid(m_axis_tid), .header_done(header_done),
        .hdr_src_id(hdr_src_id), .hdr_src_valid(hdr_src_valid),
        .tag_full(tag_full), .tag_err(tag_err), .busy(busy)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t src_q  [NP][$];
    beat_t exp_sb [NP][$];

    int n_cmp = 0;
    int n_bad = 0;
    int frame_id = 0;

    int valid_pct = 100;
    int tready_mode = 0;
    int hd_mode = 0;
    bit hd_once = 1'b0;
    logic [NP-1:0] fired = '0;

    // model state
    int   m_owner;
    int   m_last;
    int   tq[$];
    bit   m_err;
    logic [NP-1:0] s_tv_s, s_tl_s;
    logic m_tr_s, hd_s;

    int dut_beats = 0;
    int last_at = 0;
    int dut_grants[$];
    bit prev_busy = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_last  = NP - 1;
        tq.delete();
        m_err   = 1'b0;
    endfunction

    initial model_reset();

    task automatic send(input int p, input int nbeats);
        beat_t x;
        for (int b = 0; b < nbeats; b++) begin
            x.data = {8'(p), 16'(frame_id), 8'(b), 32'($urandom)};
            x.last = (b == nbeats - 1);
            src_q[p].push_back(x);
            exp_sb[p].push_back(x);
        end
        frame_id++;
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NP; i++)
            if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_drained(input int budget, input string name);
        int c = 0;
        while (!(all_empty() && !busy) && c < budget) begin
            @(negedge aclk);
            c++;
        end
        chk({name, "_timeout"}, 64'(c >= budget), 64'(0));
    endtask

    task automatic wait_tags_empty(input int budget, input string name);
        int c = 0;
        while (hdr_src_valid && c < budget) begin
            @(negedge aclk);
            c++;
        end
        chk({name, "_tags_empty"}, 64'(hdr_src_valid), 64'(0));
    endtask

    task automatic pulse_hd();
        @(posedge aclk);
        hd_once = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
    endtask

    // Stimulus driver: applies per-port sources, parser ready and header_done.
    always @(posedge aclk) begin
        #1;
        for (int i = 0; i < NP; i++) begin
            if (fired[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0 && ($urandom_range(99) < valid_pct)) begin
                s_axis_tvalid[i]           = 1'b1;
                s_axis_tdata[i*DW +: DW]   = src_q[i][0].data;
                s_axis_tlast[i]            = src_q[i][0].last;
            end else begin
                s_axis_tvalid[i]           = 1'b0;
                s_axis_tdata[i*DW +: DW]   = '0;
                s_axis_tlast[i]            = 1'b0;
            end
        end
        case (tready_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = ($urandom_range(99) < 70);
        endcase
        header_done = hd_once || (hd_mode == 1 && hdr_src_valid) ||
                      (hd_mode == 2 && $urandom_range(99) < 25);
        hd_once = 1'b0;
    end

    // Model advance on the clock edge using the inputs sampled mid-cycle.
    always @(posedge aclk) begin
        int sz;
        bit do_pop;
        int p;
        if (areset) begin
            model_reset();
        end else begin
            sz = tq.size();
            do_pop = hd_s && (sz != 0);
            if (hd_s && sz == 0) m_err = 1'b1;
            if (m_owner < 0) begin
                if (|s_tv_s && sz < TD) begin
                    for (int k = 1; k <= NP; k++) begin
                        p = (m_last + k) % NP;
                        if (s_tv_s[p]) break;
                    end
                    m_owner = p;
                    tq.push_back(p);
                end
            end else if (s_tv_s[m_owner] && m_tr_s && s_tl_s[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end
            if (do_pop) void'(tq.pop_front());
        end
    end

    // Compare process plus scoreboard and logging, away from the active edge.
    always @(negedge aclk) begin
        logic [NP-1:0] exp_rdy;
        beat_t e;
        exp_rdy = '0;
        chk("busy", 64'(busy), 64'(m_owner >= 0));
        if (m_owner >= 0) begin
            exp_rdy[m_owner] = m_axis_tready;
            chk("m_tvalid", 64'(m_axis_tvalid), 64'(s_axis_tvalid[m_owner]));
            chk("m_tid", 64'(m_axis_tid), 64'(m_owner));
            if (s_axis_tvalid[m_owner]) begin
                chk("m_tdata", m_axis_tdata, s_axis_tdata[m_owner*DW +: DW]);
                chk("m_tlast", 64'(m_axis_tlast), 64'(s_axis_tlast[m_owner]));
            end
        end else begin
            chk("m_tvalid_idle", 64'(m_axis_tvalid), 64'(0));
        end
        chk("s_tready", 64'(s_axis_tready), 64'(exp_rdy));
        chk("hdr_valid", 64'(hdr_src_valid), 64'(tq.size() != 0));
        chk("tag_full", 64'(tag_full), 64'(tq.size() == TD));
        chk("tag_err", 64'(tag_err), 64'(m_err));
        if (tq.size() != 0) chk("hdr_id", 64'(hdr_src_id), 64'(tq[0]));

        if (m_axis_tvalid && m_axis_tready) begin
            dut_beats++;
            if (m_axis_tlast) last_at = dut_beats;
            if (exp_sb[m_axis_tid].size() == 0) begin
                chk("sb_extra_beat", 64'(1), 64'(0));
            end else begin
                e = exp_sb[m_axis_tid].pop_front();
                chk("sb_data", m_axis_tdata, e.data);
                chk("sb_last", 64'(m_axis_tlast), 64'(e.last));
            end
        end
        if (busy && !prev_busy) dut_grants.push_back(int'(m_axis_tid));
        prev_busy = busy;

        s_tv_s = s_axis_tvalid;
        s_tl_s = s_axis_tlast;
        m_tr_s = m_axis_tready;
        hd_s   = header_done;
        fired  = s_axis_tvalid & s_axis_tready;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int base;
        int rr_exp[6];
        int full_exp[4];
        rr_exp   = '{0, 1, 3, 0, 1, 3};
        full_exp = '{2, 3, 0, 1};

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_s_tready", 64'(s_axis_tready), 64'(0));
        chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("rst_m_tdata", m_axis_tdata, 64'(0));
        chk("rst_m_tid", 64'(m_axis_tid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_hdr_valid", 64'(hdr_src_valid), 64'(0));
        chk("rst_tag_err", 64'(tag_err), 64'(0));
        @(posedge aclk);
        #3 areset = 1'b0;
        @(negedge aclk);

        // Single port, 8-beat frame
        dut_grants.delete();
        dut_beats = 0;
        last_at = 0;
        send(2, 8);
        c = 0;
        do begin
            @(negedge aclk);
            c++;
        end while (!s_axis_tvalid[2] && c < 10);
        chk("t1_busy_before_grant", 64'(busy), 64'(0));
        @(negedge aclk);
        chk("t1_grant_latency", 64'(busy), 64'(1));
        chk("t1_tid", 64'(m_axis_tid), 64'(2));
        wait_drained(100, "t1");
        chk("t1_ngrants", 64'(dut_grants.size()), 64'(1));
        if (dut_grants.size() > 0) chk("t1_grant", 64'(dut_grants[0]), 64'(2));
        chk("t1_beats", 64'(dut_beats), 64'(8));
        chk("t1_last_at", 64'(last_at), 64'(8));
        chk("t1_hdr_valid", 64'(hdr_src_valid), 64'(1));
        chk("t1_hdr_id", 64'(hdr_src_id), 64'(2));
        pulse_hd();
        chk("t1_hdr_popped", 64'(hdr_src_valid), 64'(0));

        // Round-robin among ports 0, 1, 3
        hd_mode = 1;
        send(3, 1);
        wait_drained(50, "t2_pre");
        dut_grants.delete();
        dut_beats = 0;
        for (int r = 0; r < 2; r++) begin
            send(0, 2);
            send(1, 2);
            send(3, 2);
        end
        wait_drained(200, "t2");
        chk("t2_ngrants", 64'(dut_grants.size()), 64'(6));
        for (int i = 0; i < 6; i++)
            if (i < dut_grants.size()) chk("t2_grant_order", 64'(dut_grants[i]), 64'(rr_exp[i]));
        chk("t2_beats", 64'(dut_beats), 64'(12));

        // Backpressure on a port-1 frame
        tready_mode = 1;
        dut_grants.delete();
        dut_beats = 0;
        send(1, 4);
        wait_drained(100, "t3");
        chk("t3_beats", 64'(dut_beats), 64'(4));
        if (dut_grants.size() > 0) chk("t3_grant", 64'(dut_grants[0]), 64'(1));
        tready_mode = 0;
        wait_tags_empty(50, "t3");
        hd_mode = 0;
        repeat (2) @(negedge aclk);

        // Tag FIFO full
        dut_grants.delete();
        send(0, 2);
        send(1, 2);
        send(2, 2);
        send(3, 2);
        send(0, 2);
        repeat (30) @(negedge aclk);
        chk("t4_full", 64'(tag_full), 64'(1));
        chk("t4_no_grant", 64'(busy), 64'(0));
        chk("t4_p0_requesting", 64'(s_axis_tvalid[0]), 64'(1));
        chk("t4_head", 64'(hdr_src_id), 64'(2));
        chk("t4_ngrants", 64'(dut_grants.size()), 64'(4));
        for (int i = 0; i < 4; i++)
            if (i < dut_grants.size()) chk("t4_grant_order", 64'(dut_grants[i]), 64'(full_exp[i]));
        pulse_hd();
        chk("t4_head_adv", 64'(hdr_src_id), 64'(3));
        chk("t4_not_full", 64'(tag_full), 64'(0));
        c = 0;
        while (!busy && c < 2) begin
            @(negedge aclk);
            c++;
        end
        chk("t4_regrant", 64'(busy), 64'(1));
        chk("t4_regrant_tid", 64'(m_axis_tid), 64'(0));
        wait_drained(50, "t4");

        // Pop on empty FIFO, then push/pop coincidence
        hd_mode = 1;
        wait_tags_empty(50, "t5");
        hd_mode = 0;
        repeat (2) @(negedge aclk);
        chk("t5_err_clear", 64'(tag_err), 64'(0));
        pulse_hd();
        chk("t5_err_set", 64'(tag_err), 64'(1));
        repeat (5) @(negedge aclk);
        chk("t5_err_sticky", 64'(tag_err), 64'(1));
        send(2, 1);
        wait_drained(50, "t5a");
        send(3, 1);
        wait_drained(50, "t5b");
        chk("t5_head2", 64'(hdr_src_id), 64'(2));
        @(posedge aclk);
        send(1, 1);
        hd_once = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        chk("t5_sim_busy", 64'(busy), 64'(1));
        chk("t5_sim_head", 64'(hdr_src_id), 64'(3));
        chk("t5_sim_not_full", 64'(tag_full), 64'(0));
        wait_drained(50, "t5c");
        pulse_hd();
        chk("t5_second_entry", 64'(hdr_src_id), 64'(1));
        chk("t5_second_valid", 64'(hdr_src_valid), 64'(1));
        pulse_hd();
        chk("t5_count2_empty", 64'(hdr_src_valid), 64'(0));

        // Reset in the middle of a port-2 frame
        send(2, 6);
        base = dut_beats;
        c = 0;
        while ((dut_beats - base) < 3 && c < 50) begin
            @(negedge aclk);
            c++;
        end
        chk("t6_reached_beat3", 64'(dut_beats - base), 64'(3));
        #2;
        areset = 1'b1;
        model_reset();
        for (int i = 0; i < NP; i++) begin
            src_q[i].delete();
            exp_sb[i].delete();
        end
        #1;
        chk("t6_s_tready", 64'(s_axis_tready), 64'(0));
        chk("t6_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("t6_m_tdata", m_axis_tdata, 64'(0));
        chk("t6_m_tlast", 64'(m_axis_tlast), 64'(0));
        chk("t6_m_tid", 64'(m_axis_tid), 64'(0));
        chk("t6_busy", 64'(busy), 64'(0));
        chk("t6_hdr_valid", 64'(hdr_src_valid), 64'(0));
        chk("t6_tag_err", 64'(tag_err), 64'(0));
        @(posedge aclk);
        @(posedge aclk);
        #3 areset = 1'b0;
        @(negedge aclk);
        dut_grants.delete();
        send(2, 2);
        send(0, 2);
        wait_drained(50, "t6");
        chk("t6_ngrants", 64'(dut_grants.size()), 64'(2));
        if (dut_grants.size() > 1) begin
            chk("t6_first_p0", 64'(dut_grants[0]), 64'(0));
            chk("t6_then_p2", 64'(dut_grants[1]), 64'(2));
        end

        // Randomised traffic
        valid_pct   = 70;
        tready_mode = 2;
        hd_mode     = 2;
        for (int k = 0; k < 1500; k++) begin
            @(negedge aclk);
            if ($urandom_range(99) < 20) begin
                c = $urandom_range(NP - 1);
                if (src_q[c].size() < 20) send(c, $urandom_range(1, 5));
            end
        end
        valid_pct   = 100;
        tready_mode = 0;
        hd_mode     = 1;
        wait_drained(3000, "rand");
        for (int i = 0; i < NP; i++)
            chk("sb_all_delivered", 64'(exp_sb[i].size()), 64'(0));
        repeat (4) @(negedge aclk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
